// File: rtl/doa_eigen_feeder_pkg.sv
// Shared definitions for the DOA eigen feeder: default widths, frame length and FSM states.
package doa_pkg;

  localparam int JACOBI_WIDTH = 32;
  localparam int N            = 4;

  // Frame = N eigenvalues followed by N complex eigenvectors of length N.
  function automatic int frame_words(input int n);
    return n + 2 * n * n;
  endfunction

  localparam int W = frame_words(N);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_ISSUE,
    S_WAIT_DONE
  } feeder_state_e;

endpackage

// File: rtl/doa_eigen_feeder_if.sv
// Eigen stream, captured arrays and DOA search handshake; master = feeder side, slave = its environment.
interface doa_eigen_feeder_if #(
  parameter int JACOBI_WIDTH = doa_pkg::JACOBI_WIDTH,
  parameter int N            = doa_pkg::N
);

  logic                           ieig_valid;
  logic signed [JACOBI_WIDTH-1:0] ieig_data;
  logic                           ieig_last;
  logic                           oeig_ready;
  logic signed [JACOBI_WIDTH-1:0] oeigen_value  [N];
  logic signed [JACOBI_WIDTH-1:0] oeigen_vector [2*N*N];
  logic                           ostart_doa_search;
  logic                           idoa_search_done;
  logic [9:0]                     iazimuth_angle;
  logic [9:0]                     oazimuth_angle;
  logic                           oresult_valid;
  logic                           oframe_err;
  logic                           otimeout;

  modport master (
    input  ieig_valid, ieig_data, ieig_last, idoa_search_done, iazimuth_angle,
    output oeig_ready, oeigen_value, oeigen_vector, ostart_doa_search,
           oazimuth_angle, oresult_valid, oframe_err, otimeout
  );

  modport slave (
    output ieig_valid, ieig_data, ieig_last, idoa_search_done, iazimuth_angle,
    input  oeig_ready, oeigen_value, oeigen_vector, ostart_doa_search,
           oazimuth_angle, oresult_valid, oframe_err, otimeout
  );

endinterface

// File: rtl/doa_eigen_feeder.sv
// Captures one eigen frame into value/vector arrays, kicks the DOA search and waits (bounded) for its result.
module doa_eigen_feeder #(
  parameter int JACOBI_WIDTH   = doa_pkg::JACOBI_WIDTH,
  parameter int N              = doa_pkg::N,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               iclk,
  input  logic               irst,
  doa_eigen_feeder_if.master bus
);

  import doa_pkg::*;

  localparam int FRAME_W = frame_words(N);
  localparam int CW      = $clog2(FRAME_W);
  localparam int VIW     = (N > 1) ? $clog2(N) : 1;
  localparam int VW      = $clog2(2 * N * N);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_C   = CW'(FRAME_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    az_q, az_d;
  logic          err_q, err_d;
  logic          res_q, res_d;
  logic          tmo_pulse_q, tmo_pulse_d;

  logic signed [JACOBI_WIDTH-1:0] value_q  [N];
  logic signed [JACOBI_WIDTH-1:0] vector_q [2*N*N];

  logic           ready;
  logic           accept;
  logic           store;
  logic [VIW-1:0] val_idx;
  logic [VW-1:0]  vec_idx;

  assign ready  = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !irst;
  assign accept = bus.ieig_valid && ready;
  assign store  = accept && (state_q == S_LOAD);

  always_comb begin
    val_idx = VIW'(cnt_q);
    vec_idx = VW'(cnt_q - CW'(N));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    az_d        = az_q;
    err_d       = 1'b0;
    res_d       = 1'b0;
    tmo_pulse_d = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (cnt_q == LAST_C) begin
            cnt_d = '0;
            if (bus.ieig_last) begin
              state_d = S_ISSUE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (bus.ieig_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (accept && bus.ieig_last) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_DONE;
        tmo_d   = '0;
      end
      S_WAIT_DONE: begin
        // done is tested first so it wins over a coincident timeout
        if (bus.idoa_search_done) begin
          az_d    = bus.iazimuth_angle;
          res_d   = 1'b1;
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            tmo_pulse_d = 1'b1;
            state_d     = S_LOAD;
            cnt_d       = '0;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      tmo_q       <= '0;
      az_q        <= '0;
      err_q       <= 1'b0;
      res_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      az_q        <= az_d;
      err_q       <= err_d;
      res_q       <= res_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int unsigned i = 0; i < N; i++) value_q[i] <= '0;
      for (int unsigned i = 0; i < 2 * N * N; i++) vector_q[i] <= '0;
    end else if (store) begin
      if (cnt_q < CW'(N)) value_q[val_idx] <= bus.ieig_data;
      else                vector_q[vec_idx] <= bus.ieig_data;
    end
  end

  assign bus.oeig_ready        = ready;
  assign bus.oeigen_value      = value_q;
  assign bus.oeigen_vector     = vector_q;
  assign bus.ostart_doa_search = (state_q == S_ISSUE) && !irst;
  assign bus.oazimuth_angle    = az_q;
  assign bus.oresult_valid     = res_q && !irst;
  assign bus.oframe_err        = err_q && !irst;
  assign bus.otimeout          = tmo_pulse_q && !irst;

endmodule

// File: tb/tb_doa_eigen_feeder.sv
// Directed bench for doa_eigen_feeder: frame capture, frame errors, DOA handshake, timeout and reset.
module tb_doa_eigen_feeder;

  import doa_pkg::*;

  logic iclk = 1'b0;
  logic irst;
  int   errors = 0;
  int   checks = 0;

  always #5 iclk = ~iclk;

  doa_eigen_feeder_if #(.JACOBI_WIDTH(32), .N(4)) bus ();

  doa_eigen_feeder #(
    .JACOBI_WIDTH  (32),
    .N             (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send_word(input int data, input bit last);
    bus.ieig_valid = 1'b1;
    bus.ieig_data  = data;
    bus.ieig_last  = last;
    tick();
    bus.ieig_valid = 1'b0;
    bus.ieig_last  = 1'b0;
  endtask

  // last_at = 0 sends no last marker
  task automatic send_frame(input int base, input int n, input int last_at);
    for (int i = 1; i <= n; i++) send_word(base + i - 1, i == last_at);
  endtask

  initial begin
    irst                 = 1'b1;
    bus.ieig_valid       = 1'b0;
    bus.ieig_data        = '0;
    bus.ieig_last        = 1'b0;
    bus.idoa_search_done = 1'b0;
    bus.iazimuth_angle   = '0;
    tick();
    tick();
    chk("rst_ready_low", bus.oeig_ready, 0);
    irst = 1'b0;
    #1;
    chk("rst_ready", bus.oeig_ready, 1);
    chk("rst_val0", bus.oeigen_value[0], 0);
    chk("rst_vec31", bus.oeigen_vector[31], 0);
    chk("rst_az", bus.oazimuth_angle, 0);
    chk("rst_start", bus.ostart_doa_search, 0);
    chk("rst_err", bus.oframe_err, 0);

    // Good frame 1..36
    send_frame(1, 36, 36);
    chk("f1_start", bus.ostart_doa_search, 1);
    chk("f1_ready", bus.oeig_ready, 0);
    chk("f1_err", bus.oframe_err, 0);
    for (int i = 0; i < 4; i++) chk("f1_val", bus.oeigen_value[i], i + 1);
    chk("f1_vec0", bus.oeigen_vector[0], 5);
    chk("f1_vec31", bus.oeigen_vector[31], 36);
    tick();
    chk("f1_start_once", bus.ostart_doa_search, 0);

    // Done five cycles after start
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_ready", bus.oeig_ready, 0);
    end
    bus.idoa_search_done = 1'b1;
    bus.iazimuth_angle   = 10'd37;
    tick();
    bus.idoa_search_done = 1'b0;
    bus.iazimuth_angle   = '0;
    chk("done_valid", bus.oresult_valid, 1);
    chk("done_az", bus.oazimuth_angle, 37);
    chk("done_ready", bus.oeig_ready, 1);
    chk("done_hold_vec31", bus.oeigen_vector[31], 36);
    tick();
    chk("done_valid_once", bus.oresult_valid, 0);
    chk("done_az_hold", bus.oazimuth_angle, 37);

    // Stray done in LOAD is ignored
    bus.idoa_search_done = 1'b1;
    bus.iazimuth_angle   = 10'd555;
    tick();
    bus.idoa_search_done = 1'b0;
    chk("stray_valid", bus.oresult_valid, 0);
    chk("stray_az", bus.oazimuth_angle, 37);
    chk("stray_ready", bus.oeig_ready, 1);

    // Short frame, then good frame
    send_frame(101, 10, 10);
    chk("short_err", bus.oframe_err, 1);
    chk("short_ready", bus.oeig_ready, 1);
    chk("short_start", bus.ostart_doa_search, 0);
    tick();
    chk("short_err_once", bus.oframe_err, 0);
    send_frame(101, 36, 36);
    chk("f2_start", bus.ostart_doa_search, 1);
    chk("f2_val0", bus.oeigen_value[0], 101);
    chk("f2_vec31", bus.oeigen_vector[31], 136);
    tick();
    bus.idoa_search_done = 1'b1;
    bus.iazimuth_angle   = 10'd5;
    tick();
    bus.idoa_search_done = 1'b0;
    chk("f2_valid", bus.oresult_valid, 1);
    chk("f2_az", bus.oazimuth_angle, 5);

    // Overlong frame: error at word 36, then drain to last
    send_frame(201, 36, 0);
    chk("long_err", bus.oframe_err, 1);
    chk("long_start", bus.ostart_doa_search, 0);
    chk("long_ready", bus.oeig_ready, 1);
    send_word(900, 1'b0);
    chk("drain_err0", bus.oframe_err, 0);
    send_word(901, 1'b0);
    send_word(902, 1'b1);
    chk("drain_err_end", bus.oframe_err, 0);
    chk("drain_start", bus.ostart_doa_search, 0);
    chk("drain_ready", bus.oeig_ready, 1);
    chk("drain_val0", bus.oeigen_value[0], 201);
    chk("drain_vec31", bus.oeigen_vector[31], 236);

    // Timeout: 8 WAIT_DONE cycles then pulse
    send_frame(301, 36, 36);
    chk("f3_start", bus.ostart_doa_search, 1);
    chk("f3_val0", bus.oeigen_value[0], 301);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tmo_wait_ready", bus.oeig_ready, 0);
      chk("tmo_wait_pulse", bus.otimeout, 0);
    end
    tick();
    chk("tmo_pulse", bus.otimeout, 1);
    chk("tmo_ready", bus.oeig_ready, 1);
    chk("tmo_valid", bus.oresult_valid, 0);
    chk("tmo_az", bus.oazimuth_angle, 5);
    tick();
    chk("tmo_pulse_once", bus.otimeout, 0);

    // Done in the same cycle as timeout: done wins
    send_frame(401, 36, 36);
    chk("f4_start", bus.ostart_doa_search, 1);
    for (int i = 0; i < 8; i++) tick();
    bus.idoa_search_done = 1'b1;
    bus.iazimuth_angle   = 10'd600;
    tick();
    bus.idoa_search_done = 1'b0;
    chk("tie_valid", bus.oresult_valid, 1);
    chk("tie_tmo", bus.otimeout, 0);
    chk("tie_az", bus.oazimuth_angle, 600);
    tick();
    chk("tie_tmo_late", bus.otimeout, 0);

    // Reset mid-frame at word 20
    send_frame(501, 20, 0);
    irst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.oeig_ready, 0);
    tick();
    chk("mid_rst_val0", bus.oeigen_value[0], 0);
    chk("mid_rst_vec31", bus.oeigen_vector[31], 0);
    chk("mid_rst_az", bus.oazimuth_angle, 0);
    chk("mid_rst_valid", bus.oresult_valid, 0);
    irst = 1'b0;
    #1;
    send_frame(1, 36, 36);
    chk("f5_start", bus.ostart_doa_search, 1);
    chk("f5_val0", bus.oeigen_value[0], 1);
    chk("f5_val3", bus.oeigen_value[3], 4);
    chk("f5_vec0", bus.oeigen_vector[0], 5);
    chk("f5_vec31", bus.oeigen_vector[31], 36);

    // Reset out of WAIT_DONE
    tick();
    irst = 1'b1;
    tick();
    irst = 1'b0;
    #1;
    chk("wait_rst_ready", bus.oeig_ready, 1);
    chk("wait_rst_start", bus.ostart_doa_search, 0);
    chk("wait_rst_vec31", bus.oeigen_vector[31], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/doa_eigen_feeder.md
DOA_EIGEN_FEEDER -- requirements
Module: doa_eigen_feeder

Interface
REQ-001 SHALL have parameter JACOBI_WIDTH, default 32, eigen word width (signed).
REQ-002 SHALL have parameter N, default 4, number of array elements; frame length W = N + 2*N*N words (36 at N=4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum cycles waiting for the DOA search to finish.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 iclk  input  1  rising-edge clock.
REQ-006 irst  input  1  synchronous active-high reset.
REQ-007 ieig_valid  input  1  upstream eigen word valid.
REQ-008 ieig_data  input  JACOBI_WIDTH  signed eigen word.
REQ-009 ieig_last  input  1  marks the final word of a frame.
REQ-010 oeig_ready  output  1  feeder accepts a word this cycle.
REQ-011 oeigen_value  output  N x JACOBI_WIDTH  captured eigenvalues, index 0..N-1.
REQ-012 oeigen_vector  output  2*N*N x JACOBI_WIDTH  captured eigenvectors; vector j occupies j*2N..j*2N+2N-1, real/imag interleaved.
REQ-013 ostart_doa_search  output  1  one-cycle start pulse to the DOA search block.
REQ-014 idoa_search_done  input  1  one-cycle done pulse from the DOA search block.
REQ-015 iazimuth_angle  input  10  azimuth result, valid with idoa_search_done.
REQ-016 oazimuth_angle  output  10  latched azimuth result.
REQ-017 oresult_valid  output  1  one-cycle pulse, new oazimuth_angle.
REQ-018 oframe_err  output  1  one-cycle pulse, malformed frame.
REQ-019 otimeout  output  1  one-cycle pulse, DOA search did not finish in time.

Function
REQ-020 States: LOAD, DRAIN, ISSUE, WAIT_DONE; a word is accepted when ieig_valid && oeig_ready.
REQ-021 oeig_ready SHALL be 1 in LOAD and DRAIN; 0 in ISSUE and WAIT_DONE; 0 in any cycle with irst=1.
REQ-022 In LOAD, accepted word at counter c SHALL write oeigen_value[c] if c<N, else oeigen_vector[c-N]; c increments by 1.
REQ-023 Accepted word with ieig_last=1 and c=W-1: store it, c<=0, go to ISSUE.
REQ-024 Accepted word with ieig_last=1 and c<W-1: oframe_err pulses the next cycle, c<=0, stay in LOAD; outputs keep previously written contents.
REQ-025 Accepted word at c=W-1 with ieig_last=0: store it, oframe_err pulses the next cycle, go to DRAIN.
REQ-026 In DRAIN, accepted words SHALL be discarded; an accepted word with ieig_last=1 returns to LOAD with c=0.
REQ-027 In ISSUE, ostart_doa_search SHALL be 1 for exactly one cycle, i.e. the cycle after the final word is accepted; next state WAIT_DONE; timeout counter cleared.
REQ-028 oeigen_value and oeigen_vector SHALL hold stable from entry to ISSUE until WAIT_DONE is left.
REQ-029 In WAIT_DONE, idoa_search_done=1 SHALL latch iazimuth_angle into oazimuth_angle, pulse oresult_valid the next cycle, and return to LOAD with c=0.
REQ-030 In WAIT_DONE, the timeout counter increments each cycle; when it reaches TIMEOUT_CYCLES without done, otimeout pulses for one cycle and the state returns to LOAD; oazimuth_angle is unchanged.
REQ-031 If done and timeout occur in the same cycle, done SHALL take priority; no otimeout pulse.
REQ-032 idoa_search_done outside WAIT_DONE SHALL be ignored.
REQ-033 Counter width SHALL be $clog2(W); the timeout counter SHALL not wrap.

Reset
REQ-034 irst=1 SHALL force LOAD, c=0, timeout counter 0, all arrays 0, oazimuth_angle 0, and all pulse outputs 0, from any state including mid-frame and WAIT_DONE.

Structure
REQ-035 Package doa_pkg SHALL hold JACOBI_WIDTH, N, the W localparam and the feeder state enum.
REQ-036 A single module SHALL be used; no sub-module is required.

Verification
REQ-037 36 consecutive words 1..36, last on word 36 -> values 1..4, vector[0]=5, vector[31]=36; ostart_doa_search one cycle after the last word is accepted.
REQ-038 Last on word 10 -> oframe_err one cycle later; a following good frame produces a normal start.
REQ-039 36 words with no last, 3 more words with last on the third -> one oframe_err, no start, then back to LOAD.
REQ-040 Start, then done with angle 10'd37 five cycles later -> oazimuth_angle=37 and one oresult_valid pulse; oeig_ready=0 until done.
REQ-041 TIMEOUT_CYCLES=8, no done -> otimeout pulse and return to LOAD; a second run with done arriving in the same cycle as the timeout -> oresult_valid, no otimeout.
REQ-042 irst asserted mid-frame (word 20) -> all outputs 0 and a new full frame is accepted normally.
